// File: rtl/jk_bank_ctrl_if.sv
// Command/readback bundle between requesters, the JK bank and jk_bank_ctrl.
// master = requesters plus bank side, slave = controller side.
interface jk_bank_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             req0;
    logic [2:0]       op0;
    logic [WIDTH-1:0] arg0;
    logic             req1;
    logic [2:0]       op1;
    logic [WIDTH-1:0] arg1;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             ack0;
    logic             ack1;
    logic             err;
    logic             busy;
    logic             grant;

    modport master (
        output req0, op0, arg0, req1, op1, arg1, q,
        input  j, k, ack0, ack1, err, busy, grant
    );

    modport slave (
        input  req0, op0, arg0, req1, op1, arg1, q,
        output j, k, ack0, ack1, err, busy, grant
    );
endinterface

// File: rtl/jk_bank_ctrl.sv
// Two-requester sequencer for a bank of JK flip-flops: set/clear/toggle/count
// commands, readback verify, and a one-cycle ack with error flag.
module jk_bank_ctrl #(
    parameter int WIDTH = 4
) (
    input logic           clk,
    input logic           reset,
    jk_bank_ctrl_if.slave bus
);
    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_CLEAR = 3'd1;
    localparam logic [2:0] OP_SET   = 3'd2;
    localparam logic [2:0] OP_TOG   = 3'd3;
    localparam logic [2:0] OP_COUNT = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_COUNT,
        S_VERIFY,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_grant;
    logic             r_last;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_arg;
    logic [WIDTH-1:0] r_qsnap;
    logic [WIDTH-1:0] r_steps;
    logic             r_err;

    logic             w_any;
    logic             w_gsel;
    logic [2:0]       w_op_in;
    logic [WIDTH-1:0] w_arg_in;
    logic             w_rsvd_in;
    logic [WIDTH-1:0] w_cnt;
    logic [WIDTH-1:0] w_sum;
    logic             w_pass;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;

    // Round-robin on a tie: the side not served last wins.
    assign w_any     = bus.req0 | bus.req1;
    assign w_gsel    = (bus.req0 & bus.req1) ? ~r_last : bus.req1;
    assign w_op_in   = w_gsel ? bus.op1 : bus.op0;
    assign w_arg_in  = w_gsel ? bus.arg1 : bus.arg0;
    assign w_rsvd_in = w_op_in[2] & (|w_op_in[1:0]);
    assign w_sum     = r_qsnap + r_arg;

    always_comb begin
        w_cnt    = '0;
        w_cnt[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            w_cnt[i] = w_cnt[i-1] & bus.q[i-1];
        end
    end

    always_comb begin
        w_pass = 1'b0;
        unique case (r_op)
            OP_NOP:   w_pass = 1'b1;
            OP_CLEAR: w_pass = (bus.q & r_arg) == '0;
            OP_SET:   w_pass = (bus.q & r_arg) == r_arg;
            OP_TOG:   w_pass = ((bus.q ^ r_qsnap) & r_arg) == r_arg;
            OP_COUNT: w_pass = bus.q == w_sum;
            default:  w_pass = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_j         = '0;
        w_k         = '0;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    if (w_rsvd_in)
                        w_state_nxt = S_DONE;
                    else if (w_op_in == OP_COUNT)
                        w_state_nxt = (w_arg_in == '0) ? S_VERIFY : S_COUNT;
                    else
                        w_state_nxt = S_APPLY;
                end
            end
            S_APPLY: begin
                w_state_nxt = S_VERIFY;
                unique case (r_op)
                    OP_CLEAR: w_k = r_arg;
                    OP_SET:   w_j = r_arg;
                    OP_TOG: begin
                        w_j = r_arg;
                        w_k = r_arg;
                    end
                    default: ;
                endcase
            end
            S_COUNT: begin
                w_j = w_cnt;
                w_k = w_cnt;
                if (r_steps == WIDTH'(1))
                    w_state_nxt = S_VERIFY;
            end
            S_VERIFY: w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_grant <= 1'b0;
            r_last  <= 1'b1;
            r_op    <= OP_NOP;
            r_arg   <= '0;
            r_qsnap <= '0;
            r_steps <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_gsel;
                        r_op    <= w_op_in;
                        r_arg   <= w_arg_in;
                        r_qsnap <= bus.q;
                        r_steps <= w_arg_in;
                        r_err   <= w_rsvd_in;
                    end
                end
                S_COUNT:  r_steps <= r_steps - 1'b1;
                S_VERIFY: r_err <= ~w_pass;
                S_DONE:   r_last <= r_grant;
                default: ;
            endcase
        end
    end

    assign bus.j     = w_j;
    assign bus.k     = w_k;
    assign bus.ack0  = (r_state == S_DONE) & ~r_grant;
    assign bus.ack1  = (r_state == S_DONE) & r_grant;
    assign bus.err   = r_err;
    assign bus.busy  = r_state != S_IDLE;
    assign bus.grant = r_grant;
endmodule

// File: doc/jk_bank_ctrl.md
Name: jk_bank_ctrl

Overview:
- Controller that sequences a WIDTH-bit bank of `jk` flip-flops sharing one clock.
- Arbitrates between two requesters, each issuing one command at a time: set, clear, toggle, or count.
- Drives the bank's J/K vectors for the required cycles, reads back q, and reports completion with an ack pulse and an error flag.

Parameters:
WIDTH, 4, number of JK flip-flops in the bank; also the width of the arg fields and count modulus 2^WIDTH

Ports:
clk  input  1  rising-edge clock, shared with the JK bank
reset  input  1  asynchronous, active-high; clears all controller state
req0  input  1  requester 0 command request; level, held until ack0
op0  input  3  requester 0 opcode
arg0  input  WIDTH  requester 0 argument: bit mask (set/clear/toggle) or step count (count)
req1  input  1  requester 1 command request
op1  input  3  requester 1 opcode
arg1  input  WIDTH  requester 1 argument
q  input  WIDTH  q outputs of the JK bank
j  output  WIDTH  J inputs to the bank
k  output  WIDTH  K inputs to the bank
ack0  output  1  one-cycle completion pulse to requester 0
ack1  output  1  one-cycle completion pulse to requester 1
err  output  1  valid only while ack0/ack1 is high; 1 = readback mismatch or reserved opcode
busy  output  1  high in every state except IDLE
grant  output  1  index of the requester being served; meaningful when busy

Behaviour:
- Opcodes:
  - 000 nop: no J/K activity; always passes.
  - 001 clear: j=0, k=arg.
  - 010 set: j=arg, k=0.
  - 011 toggle: j=k=arg.
  - 100 count: increment the bank arg times as a synchronous binary counter.
  - 101-111: reserved.
- Reset (asynchronous) forces:
  - state=IDLE; j=k=0; ack0=ack1=0; err=0; busy=0; grant=0.
  - last_served=1, so requester 0 wins the first tie.
- States: IDLE, APPLY, COUNT, VERIFY, DONE. Registered state; j/k are combinational from state, latched registers and q.
- IDLE:
  - j=k=0.
  - If any req is high: latch grant, op, arg, and snapshot q into q_snap.
  - Both req high: grant the requester not equal to last_served.
  - Next state:
    - reserved op: DONE with err_next=1.
    - count with arg=0: VERIFY.
    - count with arg>0: COUNT, steps=arg.
    - otherwise: APPLY.
- APPLY: drive j/k per opcode for exactly one cycle, then VERIFY.
- COUNT:
  - j[i]=k[i]=AND of q[i-1:0] (bit 0 always 1).
  - steps decrements each cycle; leave to VERIFY when steps reaches 1 (exactly arg cycles in COUNT).
- VERIFY: j=k=0. Compute pass on q:
  - set: (q&arg)==arg.
  - clear: (q&arg)==0.
  - toggle: ((q^q_snap)&arg)==arg.
  - count: q==(q_snap+arg) mod 2^WIDTH.
  - nop: pass.
  - Register err=!pass; go to DONE.
- DONE:
  - ack[grant]=1 for this single cycle; err valid; j=k=0.
  - Set last_served=grant; next IDLE.
  - req lines are not sampled in DONE. A req still high in the following IDLE cycle is a new command.
- Latency, req first seen high in IDLE at cycle 0:
  - set/clear/toggle/nop: APPLY c1, VERIFY c2, ack c3.
  - count N>0: COUNT c1..cN, VERIFY cN+1, ack cN+2.
  - count 0: ack c2.
  - reserved op: ack c1.
- The non-granted requester waits with req held; it is served in the IDLE cycle after DONE.
- mask=0 on set/clear/toggle: j=k=0, passes.
- op/arg changes while busy are ignored (latched copies used).
- Reset mid-operation: j/k drop to 0 immediately, no ack is issued, bank contents are left as-is.
- Count wrap-around: modulo 2^WIDTH; e.g. 4'hE + 3 = 4'h1, passes.

Test Plan:
1. Bank q=0000; req0, op=010, arg=0101 -> j=0101, k=0000 in c1 only; q=0101; ack0 at c3; err=0; busy high c1-c3.
2. req0 and req1 high together from reset, both op=011, arg=1111 -> requester 0 served first (ack0 c3, q inverted); requester 1 granted in the next IDLE cycle, q returns to original; err=0 both.
3. q=1110; req1, op=100, arg=3 -> j=k toggles per count rule for 3 cycles; q steps 1111, 0000, 0001; ack1 at c5; err=0.
4. Bank q forced/stuck so a set of arg=1000 leaves q[3]=0 -> ack at c3 with err=1.
5. req0, op=110 -> no J/K activity, ack0 at c1, err=1; count with arg=0 -> ack at c2, err=0.
6. Assert reset during COUNT with arg=10 at step 4 -> j=k=0, busy=0 immediately; no ack; next request granted to requester 0 normally.
